// File: rtl/fft3_pkg.sv
// Widths, sequencer states and operand-pair selects shared by the
// FFT stage-3 twiddle multiplier sequencer.
package fft3_pkg;

  localparam int SM_W   = 9;
  localparam int MAG_W  = 8;
  localparam int PROD_W = 17;
  localparam int OUT_W  = 18;
  localparam int UMAG_W = 2 * MAG_W;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    REL,
    SUM,
    DONE
  } state_t;

  // Product index k selects which operand pair feeds the multiplier.
  localparam logic [1:0] SEL_RR = 2'd0;
  localparam logic [1:0] SEL_II = 2'd1;
  localparam logic [1:0] SEL_RI = 2'd2;
  localparam logic [1:0] SEL_IR = 2'd3;

  typedef struct packed {
    logic [SM_W-1:0] a_re;
    logic [SM_W-1:0] a_im;
    logic [SM_W-1:0] w_re;
    logic [SM_W-1:0] w_im;
  } cops_t;

  function automatic logic [SM_W-1:0] pick_a(
    input cops_t      c,
    input logic [1:0] k
  );
    logic [SM_W-1:0] r;
    unique case (1'b1)
      (k == SEL_RR), (k == SEL_RI): r = c.a_re;
      default:                      r = c.a_im;
    endcase
    return r;
  endfunction

  function automatic logic [SM_W-1:0] pick_b(
    input cops_t      c,
    input logic [1:0] k
  );
    logic [SM_W-1:0] r;
    unique case (1'b1)
      (k == SEL_RR), (k == SEL_IR): r = c.w_re;
      default:                      r = c.w_im;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sm16_to_tc17.sv
// Sign plus 16-bit magnitude to 17-bit two's complement.
// A zero magnitude always maps to +0.
module sm16_to_tc17
  import fft3_pkg::*;
(
  input  logic              sign,
  input  logic [UMAG_W-1:0] mag,
  output logic [PROD_W-1:0] tc
);

  logic [PROD_W-1:0] ext;
  logic              neg;

  assign ext = {1'b0, mag};
  assign neg = sign && (mag != '0);
  assign tc  = neg ? (~ext + PROD_W'(1)) : ext;

endmodule

// File: rtl/twiddle_cmul_3.sv
// Stage-3 twiddle sequencer: four real products through the shared
// magnitude multiplier, combined into an 18-bit complex result.
module twiddle_cmul_3
  import fft3_pkg::*;
#(
  parameter int RDY_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SM_W-1:0]   a_re,
  input  logic [SM_W-1:0]   a_im,
  input  logic [SM_W-1:0]   w_re,
  input  logic [SM_W-1:0]   w_im,
  output logic              mul_en,
  output logic [SM_W-1:0]   mul_a,
  output logic [SM_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_prdct,
  input  logic              mul_rdy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_re,
  output logic [OUT_W-1:0]  out_im,
  output logic              err
);

  localparam int CNT_W = $clog2(RDY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(RDY_TIMEOUT - 1);

  state_t                 state_q;
  state_t                 state_d;
  cops_t                  ops_q;
  logic [1:0]             k_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [3:0][PROD_W-1:0] p_q;

  logic [SM_W-1:0]   sel_a;
  logic [SM_W-1:0]   sel_b;
  logic              prod_sign;
  logic [PROD_W-1:0] p_tc;
  logic              in_issue;
  logic              hit;
  logic              tmo;
  logic [OUT_W-1:0]  re_sum;
  logic [OUT_W-1:0]  im_sum;
  logic              prdct_unused;

  // Product sign is rebuilt from the operands; the multiplier's
  // own sign bit is not trusted.
  assign prdct_unused = mul_prdct[PROD_W-1];

  assign sel_a     = pick_a(ops_q, k_q);
  assign sel_b     = pick_b(ops_q, k_q);
  assign prod_sign = sel_a[SM_W-1] ^ sel_b[SM_W-1];

  assign in_issue = (state_q == ISSUE);
  assign hit      = in_issue && mul_rdy;
  assign tmo      = in_issue && !mul_rdy
                    && (cnt_q == CNT_LAST);

  sm16_to_tc17 u_conv (
    .sign (prod_sign),
    .mag  (mul_prdct[UMAG_W-1:0]),
    .tc   (p_tc)
  );

  assign re_sum = {p_q[SEL_RR][PROD_W-1], p_q[SEL_RR]}
                - {p_q[SEL_II][PROD_W-1], p_q[SEL_II]};
  assign im_sum = {p_q[SEL_RI][PROD_W-1], p_q[SEL_RI]}
                + {p_q[SEL_IR][PROD_W-1], p_q[SEL_IR]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    mul_en    = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ISSUE;
      end
      ISSUE: begin
        mul_en = 1'b1;
        mul_a  = sel_a;
        mul_b  = sel_b;
        if (hit)      state_d = REL;
        else if (tmo) state_d = IDLE;
      end
      REL: begin
        state_d = (k_q == SEL_IR) ? SUM : ISSUE;
      end
      SUM: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q  <= '0;
      k_q    <= '0;
      cnt_q  <= '0;
      p_q    <= '0;
      out_re <= '0;
      out_im <= '0;
      err    <= 1'b0;
    end else begin
      err <= tmo;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            ops_q <= {a_re, a_im, w_re, w_im};
            k_q   <= '0;
            cnt_q <= '0;
          end
        end
        ISSUE: begin
          if (hit) p_q[k_q] <= p_tc;
          if (hit || tmo) cnt_q <= '0;
          else            cnt_q <= cnt_q + 1'b1;
        end
        REL: begin
          if (k_q != SEL_IR) k_q <= k_q + 1'b1;
        end
        SUM: begin
          out_re <= re_sum;
          out_im <= im_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_cmul_3.sv
// Directed bench for twiddle_cmul_3 with a behavioural multiplier
// whose ready latency is set per vector.
module tb_twiddle_cmul_3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  a_re = '0;
  logic [8:0]  a_im = '0;
  logic [8:0]  w_re = '0;
  logic [8:0]  w_im = '0;
  logic        mul_en;
  logic [8:0]  mul_a;
  logic [8:0]  mul_b;
  logic [16:0] mul_prdct;
  logic        mul_rdy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] out_re;
  logic [17:0] out_im;
  logic        err;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  bit rdy_on = 1'b1;
  int en_run = 0;
  int err_cnt = 0;

  typedef struct {
    string      nm;
    logic [8:0] a_re;
    logic [8:0] a_im;
    logic [8:0] w_re;
    logic [8:0] w_im;
    int         lat;
    int         re;
    int         im;
  } vec_t;

  vec_t tbl[6];

  twiddle_cmul_3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .w_re      (w_re),
    .w_im      (w_im),
    .mul_en    (mul_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_prdct (mul_prdct),
    .mul_rdy   (mul_rdy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Multiplier model: magnitude product, deliberately wrong bit 16.
  logic [15:0] ma;
  logic [15:0] mb;
  always_comb begin
    ma = {8'd0, mul_a[7:0]};
    mb = {8'd0, mul_b[7:0]};
    mul_prdct = {~(mul_a[8] ^ mul_b[8]), ma * mb};
  end

  assign mul_rdy = mul_en && rdy_on && (en_run == lat - 1);

  always @(posedge clk) begin
    en_run <= mul_en ? en_run + 1 : 0;
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic start(input vec_t v);
    chk({v.nm, " in_ready"}, in_ready, 1);
    a_re = v.a_re;
    a_im = v.a_im;
    w_re = v.w_re;
    w_im = v.w_im;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n, output int win);
    logic prev;
    prev = 1'b0;
    n = 0;
    win = 0;
    while (!out_valid && n < 1000) begin
      if (mul_en && !prev) win++;
      prev = mul_en;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_out(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " released"}, out_valid, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int win;
    int e0;
    e0 = err_cnt;
    lat = v.lat;
    rdy_on = 1'b1;
    start(v);
    wait_done(n, win);
    chk({v.nm, " latency"}, n, 4 * (v.lat + 1) + 1);
    chk({v.nm, " windows"}, win, 4);
    chk({v.nm, " re"}, $signed(out_re), v.re);
    chk({v.nm, " im"}, $signed(out_im), v.im);
    chk({v.nm, " no err"}, err_cnt - e0, 0);
    release_out(v.nm);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " in_ready"}, in_ready, 1);
    chk({nm, " mul_en"}, mul_en, 0);
    chk({nm, " mul_ab"}, {mul_a, mul_b}, 0);
    chk({nm, " out_valid"}, out_valid, 0);
    chk({nm, " out"}, {out_re, out_im}, 0);
    chk({nm, " err"}, err, 0);
  endtask

  initial begin
    int n;
    int win;
    int e0;
    bit stable;
    logic prev;
    vec_t tv;

    tbl[0] = '{"basic", 9'h003, 9'h002, 9'h004, 9'h101, 1, 14, 5};
    tbl[1] = '{"ext", 9'h0FF, 9'h1FF, 9'h0FF, 9'h0FF, 1, 130050, 0};
    tbl[2] = '{"ext_neg", 9'h1FF, 9'h0FF, 9'h1FF, 9'h1FF, 2,
               130050, 0};
    tbl[3] = '{"negzero", 9'h100, 9'h000, 9'h007, 9'h007, 1, 0, 0};
    tbl[4] = '{"mix_l3", 9'h10A, 9'h014, 9'h064, 9'h032, 3,
               -2000, 1500};
    tbl[5] = '{"mix_l2", 9'h0C8, 9'h107, 9'h180, 9'h003, 2,
               -25579, 1496};

    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Backpressure with a competing operand set held on the input.
    lat = 1;
    start(tbl[0]);
    wait_done(n, win);
    chk("bp first re", $signed(out_re), 14);
    a_re = tbl[4].a_re;
    a_im = tbl[4].a_im;
    w_re = tbl[4].w_re;
    w_im = tbl[4].w_im;
    in_valid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || mul_en
          || $signed(out_re) != 14 || $signed(out_im) != 5)
        stable = 1'b0;
    end
    chk("bp stable", stable, 1);
    lat = tbl[4].lat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp idle after hs", in_ready, 1);
    chk("bp not taken at hs", mul_en, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp taken next", mul_en, 1);
    wait_done(n, win);
    chk("bp latency", n, 4 * (tbl[4].lat + 1) + 1);
    chk("bp re", $signed(out_re), tbl[4].re);
    chk("bp im", $signed(out_im), tbl[4].im);
    release_out("bp");

    // Multiplier never answers.
    e0 = err_cnt;
    rdy_on = 1'b0;
    start(tbl[0]);
    n = 0;
    while (!err && n < 200) begin
      if (mul_en) n++;
      @(posedge clk); #1;
    end
    chk("tmo issue cycles", n, 64);
    chk("tmo err", err, 1);
    chk("tmo idle", in_ready, 1);
    chk("tmo mul_en", mul_en, 0);
    chk("tmo no result", out_valid, 0);
    @(posedge clk); #1;
    chk("tmo err pulse", err, 0);
    chk("tmo err count", err_cnt - e0, 1);

    // Ready arrives on the terminal count of every product.
    tv = tbl[1];
    tv.nm = "terminal";
    tv.lat = 64;
    run_vec(tv);

    // Reset while k=2 is in ISSUE.
    e0 = err_cnt;
    lat = 4;
    rdy_on = 1'b1;
    start(tbl[4]);
    n = 0;
    win = 0;
    prev = 1'b0;
    while (win < 3 && n < 100) begin
      if (mul_en && !prev) win++;
      prev = mul_en;
      if (win < 3) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("mid k2 reached", win, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("mid reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid no err", err_cnt - e0, 0);
    chk("mid no result", out_valid, 0);
    run_vec(tbl[5]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
